// File: rtl/seq_mul32_pkg.sv
// ---------------------------------------------------------------------------
// seq_mul32_pkg
// Shared definitions for the sequential shift-and-add multiplier:
//   - DEFAULT_WIDTH : operand width used when the top is not overridden
//   - state_e       : controller states (IDLE, BUSY, DONE)
// ---------------------------------------------------------------------------
package seq_mul32_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/adder_w.sv
// ---------------------------------------------------------------------------
// adder_w
// WIDTH-bit unsigned adder built as a ripple of 4-bit carry-lookahead slices.
// WIDTH must be a multiple of 4.
//
// Ports:
//   a_i    [WIDTH-1:0]  first operand
//   b_i    [WIDTH-1:0]  second operand
//   cin_i               carry into the least significant slice
//   sum_o  [WIDTH-1:0]  sum bits
//   cout_o              carry out of the most significant slice
// ---------------------------------------------------------------------------
module adder_w #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    localparam int NSLICE = WIDTH / 4;

    // Carry between slices; carry[0] is the adder carry-in.
    logic [NSLICE:0] carry;

    assign carry[0] = cin_i;
    assign cout_o   = carry[NSLICE];

    // Each slice computes its internal carries directly from generate and
    // propagate terms, so only the slice-to-slice carry ripples.
    for (genvar s = 0; s < NSLICE; s++) begin : g_slice
        logic [3:0] g;
        logic [3:0] p;
        logic [3:0] c;

        assign g = a_i[4*s +: 4] & b_i[4*s +: 4];
        assign p = a_i[4*s +: 4] ^ b_i[4*s +: 4];

        assign c[0] = carry[s];
        assign c[1] = g[0] | (p[0] & carry[s]);
        assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry[s]);
        assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                    | (p[2] & p[1] & p[0] & carry[s]);
        assign carry[s+1] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                          | (p[3] & p[2] & p[1] & g[0])
                          | (p[3] & p[2] & p[1] & p[0] & carry[s]);

        assign sum_o[4*s +: 4] = p ^ c;
    end

endmodule

// File: rtl/seq_mul32.sv
// ---------------------------------------------------------------------------
// seq_mul32
// Sequential unsigned multiplier, radix-2 shift-and-add, fixed latency of
// WIDTH cycles from operand acceptance to out_valid.
//
// Parameters:
//   WIDTH  operand width, multiple of 4 between 4 and 32
//
// Ports:
//   clk                     rising-edge clock
//   rst_n                   asynchronous active-low reset
//   in_valid  / in_ready    operand handshake (ready only in IDLE)
//   x, y      [WIDTH-1:0]   multiplicand / multiplier, sampled on accept
//   abort                   synchronous cancel of the current operation
//   out_valid / out_ready   result handshake (valid only in DONE)
//   product   [2*WIDTH-1:0] x*y while in DONE, 0 while in IDLE
// ---------------------------------------------------------------------------
module seq_mul32
    import seq_mul32_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    input  logic                 abort,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    // One extra bit so the counter can represent WIDTH without wrapping.
    localparam int               CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

    state_e                 state_q,     state_d;
    logic [2*WIDTH-1:0]     acc_q,       acc_d;
    logic [WIDTH-1:0]       mcand_q,     mcand_d;
    logic [CW-1:0]          cnt_q,       cnt_d;
    logic                   in_ready_q,  in_ready_d;
    logic                   out_valid_q, out_valid_d;

    logic [WIDTH-1:0]       addend;
    logic [WIDTH-1:0]       sum_hi;
    logic                   sum_c;

    // The multiplicand is added only when the current multiplier bit is set.
    assign addend = acc_q[0] ? mcand_q : '0;

    adder_w #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a_i    (acc_q[2*WIDTH-1:WIDTH]),
        .b_i    (addend),
        .cin_i  (1'b0),
        .sum_o  (sum_hi),
        .cout_o (sum_c)
    );

    // Next-state logic. The accumulator is cleared whenever the controller
    // returns to IDLE, so the product output can be driven straight from it
    // and still read zero while idle.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid && !abort) begin
                    state_d    = BUSY;
                    mcand_d    = x;
                    acc_d      = {{WIDTH{1'b0}}, y};
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                end
            end

            BUSY: begin
                if (abort) begin
                    state_d     = IDLE;
                    acc_d       = '0;
                    mcand_d     = '0;
                    cnt_d       = '0;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                end else begin
                    // Carry is kept as the new top bit so nothing is lost.
                    acc_d = {sum_c, sum_hi, acc_q[WIDTH-1:1]};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                    end
                end
            end

            DONE: begin
                if (abort || out_ready) begin
                    state_d     = IDLE;
                    acc_d       = '0;
                    mcand_d     = '0;
                    cnt_d       = '0;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                end
            end

            default: begin
                state_d     = IDLE;
                acc_d       = '0;
                mcand_d     = '0;
                cnt_d       = '0;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            mcand_q     <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign product   = acc_q;

endmodule

// File: tb/tb_seq_mul32.sv
// ---------------------------------------------------------------------------
// tb_seq_mul32
// Directed bench for seq_mul32 at the default width. Issued operations push
// their hand-computed product and accept cycle into queues; a monitor pops
// them when the DUT presents a result.
// ---------------------------------------------------------------------------
module tb_seq_mul32;

    localparam int W = 32;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             abort     = 1'b0;
    logic             out_ready = 1'b1;
    logic [W-1:0]     x         = '0;
    logic [W-1:0]     y         = '0;
    logic             in_ready;
    logic             out_valid;
    logic [2*W-1:0]   product;

    int               total      = 0;
    int               bad        = 0;
    int               cycle      = 0;
    int               validRises = 0;
    int               acceptK    = 0;
    bit               prevValid  = 1'b0;
    logic [2*W-1:0]   expQ[$];
    int               acceptQ[$];

    seq_mul32 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    // Free-running clock and an edge counter for latency measurement.
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [2*W-1:0] act,
                               input logic [2*W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%h, want 0x%h", name, act, exp);
        end
    endtask

    // Monitor: samples mid low-phase, after the driver has set this cycle's
    // inputs, and scores latency on each rising out_valid and the product on
    // each real handshake.
    always begin
        @(negedge clk);
        #2;
        if (out_valid && !prevValid) begin
            validRises++;
            if (acceptQ.size() > 0) begin
                acceptK = acceptQ.pop_front();
                checkOutput("latency", (2*W)'(cycle - acceptK), (2*W)'(W));
            end
        end
        prevValid = out_valid;
        if (out_valid && out_ready && !abort) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected result: got 0x%h, want none", product);
            end else begin
                checkOutput("product", product, expQ.pop_front());
            end
        end
    end

    // Waits for in_ready, presents one operand pair for a single edge, then
    // scrambles x/y so later changes cannot leak into the result.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2*W-1:0] exp, input bit track);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("[TB] FAIL accept timeout: got in_ready=0, want 1");
            return;
        end
        in_valid = 1'b1;
        x        = a;
        y        = b;
        @(negedge clk);
        in_valid = 1'b0;
        x        = $urandom;
        y        = $urandom;
        if (track) begin
            expQ.push_back(exp);
            acceptQ.push_back(cycle);
        end
    endtask

    task automatic waitValid();
        int n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            total++;
            bad++;
            $display("[TB] FAIL out_valid timeout: got 0, want 1");
        end
    endtask

    task automatic waitIdle();
        int n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("[TB] FAIL idle timeout: got in_ready=0, want 1");
        end
    endtask

    initial begin
        int busyReady;
        int r0;
        int n;

        $display("[TB] reset");
        repeat (2) @(negedge clk);
        checkOutput("reset in_ready", (2*W)'(in_ready), 1);
        checkOutput("reset out_valid", (2*W)'(out_valid), 0);
        checkOutput("reset product", product, 0);
        rst_n = 1'b1;

        // 3 x 5, with in_ready held low from accept through DONE.
        $display("[TB] 3 x 5");
        applyStimulus(32'd3, 32'd5, 64'h000000000000000F, 1'b1);
        busyReady = 0;
        repeat (33) begin
            if (in_ready) busyReady++;
            @(negedge clk);
        end
        checkOutput("in_ready while busy", (2*W)'(busyReady), 0);

        $display("[TB] directed products");
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 1'b1);
        applyStimulus(32'hFFFFFFFF, 32'h00000001, 64'h00000000FFFFFFFF, 1'b1);
        applyStimulus(32'h80000000, 32'h00000002, 64'h0000000100000000, 1'b1);
        applyStimulus(32'h00000000, 32'hDEADBEEF, 64'h0000000000000000, 1'b1);
        applyStimulus(32'h00010000, 32'h00010000, 64'h0000000100000000, 1'b1);

        // Backpressure: result must hold for 10 cycles, then IDLE one edge
        // after out_ready rises.
        $display("[TB] backpressure");
        waitIdle();
        out_ready = 1'b0;
        applyStimulus(32'h12345678, 32'h9ABCDEF0, 64'h0B00EA4E242D2080, 1'b1);
        waitValid();
        repeat (10) begin
            checkOutput("held product", product, 64'h0B00EA4E242D2080);
            checkOutput("held out_valid", (2*W)'(out_valid), 1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("idle after accept", (2*W)'(in_ready), 1);
        checkOutput("idle product", product, 0);

        // Abort during BUSY, then abort racing in_valid in IDLE.
        $display("[TB] abort");
        r0 = validRises;
        applyStimulus(32'h0000AAAA, 32'h00005555, 64'h0, 1'b0);
        repeat (11) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort busy in_ready", (2*W)'(in_ready), 1);
        checkOutput("abort busy product", product, 0);
        in_valid = 1'b1;
        abort    = 1'b1;
        x        = 32'd9;
        y        = 32'd9;
        @(negedge clk);
        in_valid = 1'b0;
        abort    = 1'b0;
        checkOutput("abort idle in_ready", (2*W)'(in_ready), 1);
        repeat (40) @(negedge clk);
        checkOutput("no out_valid after abort", (2*W)'(validRises), (2*W)'(r0));

        // Abort wins over out_ready in DONE: no handshake, straight to IDLE.
        applyStimulus(32'd5, 32'd5, 64'd25, 1'b0);
        waitValid();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort done in_ready", (2*W)'(in_ready), 1);
        checkOutput("abort done out_valid", (2*W)'(out_valid), 0);
        checkOutput("abort done product", product, 0);

        // Reset mid-operation, asynchronous to the clock.
        $display("[TB] reset mid-op");
        applyStimulus(32'h00001234, 32'h00005678, 64'h0, 1'b0);
        repeat (19) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async rst in_ready", (2*W)'(in_ready), 1);
        checkOutput("async rst out_valid", (2*W)'(out_valid), 0);
        checkOutput("async rst product", product, 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(32'd7, 32'd6, 64'd42, 1'b1);
        applyStimulus(32'd1, 32'd0, 64'd0, 1'b1);

        n = 0;
        while (expQ.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("results outstanding", (2*W)'(expQ.size()), 0);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_mul32.md
SEQ_MUL32 -- requirements
Module: seq_mul32

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width in bits; legal values are multiples of 4 from 4 to 32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: operands on x and y are valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-006 The block SHALL have port x, input, WIDTH bits: unsigned multiplicand.
REQ-007 The block SHALL have port y, input, WIDTH bits: unsigned multiplier.
REQ-008 The block SHALL have port abort, input, 1 bit: synchronous cancel of the operation in progress.
REQ-009 The block SHALL have port out_valid, output, 1 bit: product is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the product.
REQ-011 The block SHALL have port product, output, 2*WIDTH bits: unsigned x*y.

Function
REQ-012 The block SHALL implement states IDLE, BUSY and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-014 Accept: IDLE with in_valid=1 and abort=0 at a rising edge -> latch x into the multiplicand register, load acc = {WIDTH'b0, y}, clear the step counter, go to BUSY.
REQ-015 Each BUSY cycle: if acc[0]=1, then {c, hi} = acc[2W-1:W] + multiplicand, otherwise {c, hi} = {0, acc[2W-1:W]}; then acc <= {c, hi, acc[W-1:1]}, and the counter increments.
REQ-016 The sum SHALL be W+1 bits wide with the carry retained; no overflow or truncation of the 2W-bit result is permitted.
REQ-017 After exactly WIDTH BUSY cycles, the state SHALL go to DONE. If operands are accepted at edge k, out_valid SHALL rise at edge k+WIDTH (32 cycles at the default).
REQ-018 Latency SHALL be fixed, with no early termination for zero operands.
REQ-019 product SHALL equal acc, and SHALL be held stable in DONE until out_valid and out_ready are both 1.
REQ-020 DONE with out_ready=1 -> IDLE on the next edge. No new operand is accepted in that same cycle (in_ready=0 in DONE).
REQ-021 abort=1 in BUSY or DONE -> IDLE on the next edge with no out_valid pulse; the partial result is discarded.
REQ-022 abort=1 in IDLE together with in_valid=1 -> nothing is accepted; abort wins.
REQ-023 abort takes priority over out_ready in DONE. The product is dropped, and the consumer SHALL NOT count a handshake unless out_valid was 1 at that edge.
REQ-024 x and y changing while in BUSY or DONE SHALL have no effect on the result.
REQ-025 product SHALL be 0 whenever the state is IDLE.

Reset
REQ-026 rst_n=0 SHALL immediately, without waiting for clk, force: state IDLE, acc 0, multiplicand 0, counter 0, in_ready 1, out_valid 0, product 0.
REQ-027 Reset asserted mid-operation SHALL abandon the operation; no out_valid pulse follows the release of reset.
REQ-028 On the first edge after rst_n rises, the block SHALL be able to accept operands.

Structure
REQ-029 A shared package SHALL hold the state enumeration (IDLE, BUSY, DONE) and the default WIDTH constant.
REQ-030 The W-bit addition SHALL be one sub-module, adder_w. It is a ripple of 4-bit carry-lookahead slices, with cin=0 and carry-out exposed; seq_mul32 instantiates it once.
REQ-031 The counter width SHALL be $clog2(WIDTH)+1 bits, so it never wraps before reaching WIDTH.

Verification
REQ-032 3 x 5 accepted at edge k -> out_valid=1 at edge k+32, product=0x000000000000000F, in_ready=0 during cycles k+1..k+32.
REQ-033 0xFFFFFFFF x 0xFFFFFFFF -> product=0xFFFFFFFE00000001, which checks carry retention.
REQ-034 0x12345678 x 0x9ABCDEF0 with out_ready=0 for 10 cycles after out_valid -> product=0x0B00EA4E242D2080 held stable, and IDLE one edge after out_ready=1.
REQ-035 0x0 x 0xDEADBEEF -> product=0 after exactly 32 cycles; also, abort at BUSY cycle 12 -> IDLE next edge, no out_valid.
REQ-036 rst_n pulled low at BUSY cycle 20 -> outputs at reset values at once, no out_valid afterwards; the next operation 7 x 6 -> product=42.
